mem_access_unit: RTL
====================

// Module: mem_access_unit
// PURPOSE
//  MEM stage of the 5-stage pipeline: between EX/MEM register and MEM/WB register.
//  Issues loads/stores to data RAM over a req/ack handshake; aligns store lanes, extracts/extends load data.
//  Produces {result, write_reg_en, write_reg_addr} for MEM/WB; raises stall_req while a bus access is pending.
// PARAMETERS
//  ADDR_WIDTH  32  data-bus address width
//  DATA_WIDTH  32  data-bus/register width (fixed 4 byte lanes)
// PORTS
//  clk                 in   1   clock
//  rst                 in   1   synchronous reset, active-high
//  flush               in   1   kill instruction currently in MEM
//  mem_en              in   1   instruction is load/store
//  mem_write           in   1   1=store, 0=load
//  mem_size            in   2   00 byte, 01 half, 10 word (11 illegal: treated as word)
//  mem_sign_ext        in   1   load sign-extends (1) or zero-extends (0)
//  addr                in   32  effective address
//  store_data          in   32  store data, right-aligned
//  result_in           in   32  ALU result from EX
//  write_reg_en_in     in   1   writeback enable from EX
//  write_reg_addr_in   in   5   destination register
//  ram_req             out  1   bus request
//  ram_we              out  4   byte strobes (0 for loads)
//  ram_addr            out  32  word-aligned address ({addr[31:2],2'b00})
//  ram_wdata           out  32  lane-replicated store data
//  ram_ack             in   1   request accepted; ram_rdata valid this cycle for loads
//  ram_rdata           in   32  read data
//  stall_req           out  1   hold IF..MEM and bubble MEM/WB
//  addr_err            out  1   misaligned access (MEM_ADDR_CHECK_EN only; else tied 0)
//  result_out          out  32  to MEM/WB
//  write_reg_en_out    out  1   to MEM/WB
//  write_reg_addr_out  out  5   to MEM/WB
// BEHAVIOUR
//  - FSM: IDLE, WAIT, DRAIN. Reset -> IDLE; all outputs 0 during/after reset; no req issued.
//  - IDLE: mem_en&!flush -> ram_req=1 combinationally from inputs. ack same cycle: done, no stall.
//    No ack: capture req fields (addr, we, wdata, size, sign) into regs, stall_req=1, -> WAIT.
//  - WAIT: ram_req=1 driven from captured regs (stable until ack). stall_req=1 until ack cycle.
//    ack: stall_req=0 that cycle, load data muxed to result_out, -> IDLE.
//    flush in WAIT: -> DRAIN; write_reg_en_out=0 from that cycle.
//  - DRAIN: req held from captured regs until ack; data discarded; stall_req=1 until ack (no new req
//    may overlap); ack -> IDLE, stall_req=0.
//  - Exactly one bus transaction outstanding; ram_req never dropped before ack once raised.
//  - Store strobes (little-endian): byte 0001<<addr[1:0]; half addr[1]?1100:0011; word 1111.
//    wdata: byte {4{d[7:0]}}, half {2{d[15:0]}}, word d.
//  - Load: lane = ram_rdata >> (8*addr[1:0]) (half uses addr[1]); extend per mem_sign_ext to 32.
//  - result_out = load ? aligned load data : result_in. write_reg_en_out = write_reg_en_in&!flush,
//    forced 0 while stall_req=1 (bubble). write_reg_addr_out passes through.
//  - mem_en=0: pure passthrough, zero latency, no stall.
//  - rst mid-WAIT/DRAIN: FSM -> IDLE, req dropped; bus slave is reset together.
// CONFIGURATION
//  MEM_ADDR_CHECK_EN defined: half with addr[0]!=0 or word with addr[1:0]!=0 -> addr_err=1 that
//    cycle, no ram_req, write_reg_en_out=0, no stall. Undefined: addr_err tied 0, low bits ignored
//    for half (addr[0]) and word (addr[1:0]); access proceeds.
// STRUCTURE
//  - Shared header (bus.v): DATA_BUS/REG_ADDR_BUS widths; mem_size encodings (MEM_SIZE_BYTE/HALF/WORD).
//  - FSM state encodings local localparams.
//  - Sub-module mem_load_align: combinational lane select + sign/zero extend (size, sign, addr[1:0], rdata).
// TESTING
//  - Word store 0xDEADBEEF @0x100, ack same cycle -> ram_we=1111, ram_addr=0x100, stall_req never 1.
//  - Byte store 0xAB @0x103, ack after 3 cycles -> ram_we=1000, wdata=0xABABABAB, stall_req 3 cycles, req stable.
//  - Load byte signed @0x102, rdata=0x0080FF00 -> result_out=0xFFFFFF80; unsigned -> 0x00000080.
//  - Load half @0x102 signed, rdata=0x8001_0000 ack delayed 2 -> result_out=0xFFFF8001 in ack cycle only.
//  - Flush in WAIT then ack 4 cycles later -> req held with original addr, write_reg_en_out=0, stall until ack.
//  - MEM_ADDR_CHECK_EN: word load @0x101 -> addr_err=1, ram_req=0; undefined -> ram_addr=0x100, req issued.

Source files
------------

// File: rtl/mem_access_unit_pkg.sv
// ---------------------------------------------------------------------------
// mem_access_unit_pkg
//   Shared definitions for the MEM pipeline stage:
//     - data/register-address bus widths
//     - mem_size encodings (byte / half / word, 2'b11 behaves as word)
//     - helpers that build little-endian store strobes and lane-replicated
//       store data from a right-aligned operand
// ---------------------------------------------------------------------------
package mem_access_unit_pkg;

  localparam int DATA_BUS     = 32;
  localparam int REG_ADDR_BUS = 5;

  localparam logic [1:0] MEM_SIZE_BYTE = 2'b00;
  localparam logic [1:0] MEM_SIZE_HALF = 2'b01;
  localparam logic [1:0] MEM_SIZE_WORD = 2'b10;

  // Byte-lane strobes for a store. Half accesses only look at addr[1] and
  // word accesses ignore the low bits entirely, so misaligned requests land
  // on the containing aligned half/word.
  function automatic logic [3:0] store_strobe(input logic [1:0] size,
                                              input logic [1:0] addr_lo);
    logic [3:0] strb;
    case (size)
      MEM_SIZE_BYTE: strb = 4'b0001 << addr_lo;
      MEM_SIZE_HALF: strb = addr_lo[1] ? 4'b1100 : 4'b0011;
      default:       strb = 4'b1111;
    endcase
    return strb;
  endfunction

  // Replicate the operand across all lanes so the slave only needs strobes.
  function automatic logic [DATA_BUS-1:0] store_lanes(input logic [1:0] size,
                                                      input logic [DATA_BUS-1:0] data);
    logic [DATA_BUS-1:0] lanes;
    case (size)
      MEM_SIZE_BYTE: lanes = {4{data[7:0]}};
      MEM_SIZE_HALF: lanes = {2{data[15:0]}};
      default:       lanes = data;
    endcase
    return lanes;
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// ---------------------------------------------------------------------------
// mem_load_align
//   Combinational load-data aligner: selects the addressed byte/half lane of
//   a 32-bit read word and sign- or zero-extends it to 32 bits.
//   Ports:
//     i_size      in  2   access size (byte/half/word; 2'b11 treated as word)
//     i_sign_ext  in  1   1 = sign-extend, 0 = zero-extend
//     i_addr_lo   in  2   addr[1:0] of the access
//     i_rdata     in  32  raw read word from the data RAM
//     o_data      out 32  aligned and extended load result
// ---------------------------------------------------------------------------
module mem_load_align
  import mem_access_unit_pkg::*;
(
  input  logic [1:0]          i_size,
  input  logic                i_sign_ext,
  input  logic [1:0]          i_addr_lo,
  input  logic [DATA_BUS-1:0] i_rdata,
  output logic [DATA_BUS-1:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    case (i_addr_lo)
      2'd0:    w_byte = i_rdata[7:0];
      2'd1:    w_byte = i_rdata[15:8];
      2'd2:    w_byte = i_rdata[23:16];
      default: w_byte = i_rdata[31:24];
    endcase
    // addr[0] is ignored for halves: a misaligned half reads the aligned one.
    w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];

    case (i_size)
      MEM_SIZE_BYTE: o_data = {{24{i_sign_ext & w_byte[7]}}, w_byte};
      MEM_SIZE_HALF: o_data = {{16{i_sign_ext & w_half[15]}}, w_half};
      default:       o_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// ---------------------------------------------------------------------------
// mem_access_unit
//   MEM stage of the 5-stage pipeline (between EX/MEM and MEM/WB). Issues
//   loads/stores to the data RAM over a req/ack handshake, aligns store
//   lanes, aligns/extends load data and stalls the pipe while a bus access
//   is outstanding. Exactly one bus transaction may be in flight.
//
//   Optional feature macro: MEM_ADDR_CHECK_EN
//     defined   -> misaligned half/word accesses raise addr_err, issue no
//                  request and suppress writeback.
//     undefined -> addr_err tied 0; low address bits are ignored for half
//                  and word accesses and the access proceeds.
//
//   Ports:
//     clk, rst (sync, active-high)
//     flush                      kill the instruction currently in MEM
//     mem_en/mem_write/mem_size/mem_sign_ext/addr/store_data  access request
//     result_in/write_reg_en_in/write_reg_addr_in             from EX/MEM
//     ram_req/ram_we/ram_addr/ram_wdata  -> data RAM
//     ram_ack/ram_rdata                  <- data RAM
//     stall_req                  hold IF..MEM, bubble MEM/WB
//     addr_err                   misaligned access (checked build only)
//     result_out/write_reg_en_out/write_reg_addr_out  -> MEM/WB
// ---------------------------------------------------------------------------
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    mem_en,
  input  logic                    mem_write,
  input  logic [1:0]              mem_size,
  input  logic                    mem_sign_ext,
  input  logic [ADDR_WIDTH-1:0]   addr,
  input  logic [DATA_WIDTH-1:0]   store_data,
  input  logic [DATA_WIDTH-1:0]   result_in,
  input  logic                    write_reg_en_in,
  input  logic [REG_ADDR_BUS-1:0] write_reg_addr_in,
  output logic                    ram_req,
  output logic [3:0]              ram_we,
  output logic [ADDR_WIDTH-1:0]   ram_addr,
  output logic [DATA_WIDTH-1:0]   ram_wdata,
  input  logic                    ram_ack,
  input  logic [DATA_WIDTH-1:0]   ram_rdata,
  output logic                    stall_req,
  output logic                    addr_err,
  output logic [DATA_WIDTH-1:0]   result_out,
  output logic                    write_reg_en_out,
  output logic [REG_ADDR_BUS-1:0] write_reg_addr_out
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_next;

  // Request fields captured when an access does not complete in its first
  // cycle; they drive the bus until ack so the request stays stable even if
  // the upstream inputs change.
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [3:0]            r_we;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [1:0]            r_size;
  logic                  r_sign;
  logic                  r_write;

  logic                  w_capture;
  logic                  w_misalign;
  logic [3:0]            w_in_we;
  logic [DATA_WIDTH-1:0] w_in_wdata;
  logic [1:0]            w_al_size;
  logic                  w_al_sign;
  logic [1:0]            w_al_lo;
  logic [DATA_WIDTH-1:0] w_load_data;

  assign w_in_we    = mem_write ? store_strobe(mem_size, addr[1:0]) : 4'b0000;
  assign w_in_wdata = mem_write ? store_lanes(mem_size, store_data) : '0;

`ifdef MEM_ADDR_CHECK_EN
  always_comb begin
    case (mem_size)
      MEM_SIZE_BYTE: w_misalign = 1'b0;
      MEM_SIZE_HALF: w_misalign = addr[0];
      default:       w_misalign = (addr[1:0] != 2'b00);
    endcase
  end
`else
  assign w_misalign = 1'b0;
`endif

  // In IDLE the access completes from the live inputs; afterwards the
  // captured size/sign/offset select the lane.
  assign w_al_size = (r_state == ST_IDLE) ? mem_size     : r_size;
  assign w_al_sign = (r_state == ST_IDLE) ? mem_sign_ext : r_sign;
  assign w_al_lo   = (r_state == ST_IDLE) ? addr[1:0]    : r_addr[1:0];

  mem_load_align u_load_align (
    .i_size     (w_al_size),
    .i_sign_ext (w_al_sign),
    .i_addr_lo  (w_al_lo),
    .i_rdata    (ram_rdata),
    .o_data     (w_load_data)
  );

  always_comb begin
    w_state_next       = r_state;
    w_capture          = 1'b0;
    ram_req            = 1'b0;
    ram_we             = 4'b0000;
    ram_addr           = '0;
    ram_wdata          = '0;
    stall_req          = 1'b0;
    addr_err           = 1'b0;
    result_out         = result_in;
    write_reg_en_out   = write_reg_en_in & ~flush;
    write_reg_addr_out = write_reg_addr_in;

    case (r_state)
      ST_IDLE: begin
        if (mem_en && !flush) begin
          if (w_misalign) begin
            addr_err         = 1'b1;
            write_reg_en_out = 1'b0;
          end else begin
            ram_req   = 1'b1;
            ram_we    = w_in_we;
            ram_addr  = {addr[ADDR_WIDTH-1:2], 2'b00};
            ram_wdata = w_in_wdata;
            if (ram_ack) begin
              if (!mem_write) result_out = w_load_data;
            end else begin
              stall_req        = 1'b1;
              write_reg_en_out = 1'b0;
              w_capture        = 1'b1;
              w_state_next     = ST_WAIT;
            end
          end
        end
      end

      ST_WAIT: begin
        ram_req   = 1'b1;
        ram_we    = r_we;
        ram_addr  = {r_addr[ADDR_WIDTH-1:2], 2'b00};
        ram_wdata = r_wdata;
        if (flush) begin
          // Instruction killed: finish the bus handshake but drop the result.
          write_reg_en_out = 1'b0;
          if (ram_ack) begin
            w_state_next = ST_IDLE;
          end else begin
            stall_req    = 1'b1;
            w_state_next = ST_DRAIN;
          end
        end else if (ram_ack) begin
          if (!r_write) result_out = w_load_data;
          w_state_next = ST_IDLE;
        end else begin
          stall_req        = 1'b1;
          write_reg_en_out = 1'b0;
        end
      end

      ST_DRAIN: begin
        // Keep stalling so no new request overlaps the orphaned one.
        ram_req          = 1'b1;
        ram_we           = r_we;
        ram_addr         = {r_addr[ADDR_WIDTH-1:2], 2'b00};
        ram_wdata        = r_wdata;
        write_reg_en_out = 1'b0;
        if (ram_ack) begin
          w_state_next = ST_IDLE;
        end else begin
          stall_req = 1'b1;
        end
      end

      default: begin
        w_state_next = ST_IDLE;
      end
    endcase

    // Reset quiets every output; the bus slave is reset alongside.
    if (rst) begin
      w_state_next       = ST_IDLE;
      w_capture          = 1'b0;
      ram_req            = 1'b0;
      ram_we             = 4'b0000;
      ram_addr           = '0;
      ram_wdata          = '0;
      stall_req          = 1'b0;
      addr_err           = 1'b0;
      result_out         = '0;
      write_reg_en_out   = 1'b0;
      write_reg_addr_out = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_addr  <= '0;
      r_we    <= 4'b0000;
      r_wdata <= '0;
      r_size  <= MEM_SIZE_BYTE;
      r_sign  <= 1'b0;
      r_write <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_capture) begin
        r_addr  <= addr;
        r_we    <= w_in_we;
        r_wdata <= w_in_wdata;
        r_size  <= mem_size;
        r_sign  <= mem_sign_ext;
        r_write <= mem_write;
      end
    end
  end

endmodule
